// File: rtl/alu_ctrl_pkg.sv
// Shared constants, FIFO state encoding and entry layout for the ALU issue block.
// ALU_ISSUE_ILLEGAL_EN adds a per-entry illegal flag.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1011;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b10
  } fifo_state_e;

  typedef struct packed {
    logic [3:0] ctrl;
    logic       imm_sel;
    logic       shamt_sel;
`ifdef ALU_ISSUE_ILLEGAL_EN
    logic       illegal;
`endif
  } alu_entry_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational MIPS opcode/funct to ALU control decoder.
// Sets the illegal flag only when ALU_ISSUE_ILLEGAL_EN is defined.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output alu_entry_t entry_o
);

  always_comb begin
    entry_o      = '0;
    entry_o.ctrl = ALU_ADD;
    unique case (1'b1)
      (opcode_i == OP_RTYPE): begin
        unique case (funct_i)
          FN_ADDU: entry_o.ctrl = ALU_ADD;
          FN_SUBU: entry_o.ctrl = ALU_SUB;
          FN_AND:  entry_o.ctrl = ALU_AND;
          FN_OR:   entry_o.ctrl = ALU_OR;
          FN_SLT:  entry_o.ctrl = ALU_SLT;
          FN_SLTU: entry_o.ctrl = ALU_SLTU;
          FN_SRA: begin
            entry_o.ctrl      = ALU_SRA;
            entry_o.shamt_sel = 1'b1;
          end
          FN_SRAV: entry_o.ctrl = ALU_SRA;
          default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
            entry_o.illegal = 1'b1;
`endif
          end
        endcase
      end
      (opcode_i == OP_BEQ),
      (opcode_i == OP_BNE): entry_o.ctrl = ALU_SUB;
      (opcode_i == OP_ADDI): begin
        entry_o.ctrl    = ALU_ADD;
        entry_o.imm_sel = 1'b1;
      end
      (opcode_i == OP_SLTIU): begin
        entry_o.ctrl    = ALU_SLTU;
        entry_o.imm_sel = 1'b1;
      end
      (opcode_i == OP_ORI): begin
        entry_o.ctrl    = ALU_OR;
        entry_o.imm_sel = 1'b1;
      end
      (opcode_i == OP_LUI): begin
        entry_o.ctrl    = ALU_LUI;
        entry_o.imm_sel = 1'b1;
      end
      default: begin
`ifdef ALU_ISSUE_ILLEGAL_EN
        entry_o.illegal = 1'b1;
`endif
      end
    endcase
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Decode-and-issue stage: decodes ALU ops into a 2-entry in-order FIFO.
// ALU_ISSUE_ILLEGAL_EN adds illegal_o and a saturating illegal_cnt_o.
module alu_ctrl_issue
  import alu_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       instr_valid_i,
  output logic       instr_ready_o,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic       ctrl_valid_o,
  input  logic       ctrl_ready_i,
  output logic [3:0] ctrl_o,
  output logic       imm_sel_o,
`ifdef ALU_ISSUE_ILLEGAL_EN
  output logic       shamt_sel_o,
  output logic       illegal_o,
  output logic [7:0] illegal_cnt_o
`else
  output logic       shamt_sel_o
`endif
);

  fifo_state_e state_q, state_d;
  alu_entry_t  head_q, head_d;
  alu_entry_t  tail_q, tail_d;
  alu_entry_t  dec_e;
  logic        ready_q, ready_d;
  logic        push, pop;

  alu_ctrl_dec u_dec (
    .opcode_i (opcode_i),
    .funct_i  (funct_i),
    .entry_o  (dec_e)
  );

  // ready is a flop so it stays low through reset and rises on the first edge
  assign push = instr_valid_i & ready_q;
  assign pop  = (state_q != ST_EMPTY) & ctrl_ready_i;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d = ST_HALF;
          head_d  = dec_e;
        end
      end
      ST_HALF: begin
        if (push && pop) begin
          head_d = dec_e;
        end else if (push) begin
          state_d = ST_FULL;
          tail_d  = dec_e;
        end else if (pop) begin
          state_d = ST_EMPTY;
          head_d  = '0;
        end
      end
      ST_FULL: begin
        if (pop) begin
          state_d = ST_HALF;
          head_d  = tail_q;
          tail_d  = '0;
        end
      end
      default: begin
        state_d = ST_EMPTY;
        head_d  = '0;
        tail_d  = '0;
      end
    endcase
    ready_d = (state_d != ST_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

  assign instr_ready_o = ready_q;
  assign ctrl_valid_o  = (state_q != ST_EMPTY);
  assign ctrl_o        = head_q.ctrl;
  assign imm_sel_o     = head_q.imm_sel;
  assign shamt_sel_o   = head_q.shamt_sel;

`ifdef ALU_ISSUE_ILLEGAL_EN
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (push && dec_e.illegal && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= 8'h00;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign illegal_o     = head_q.illegal;
  assign illegal_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed table-driven bench for alu_ctrl_issue.
// Build with ALU_ISSUE_ILLEGAL_EN to cover the illegal flag and counter.
module tb_alu_ctrl_issue;

  logic       clk;
  logic       rst;
  logic       iv;
  logic       ir;
  logic [5:0] op;
  logic [5:0] fn;
  logic       cv;
  logic       cr;
  logic [3:0] ctrl;
  logic       imm;
  logic       sh;
`ifdef ALU_ISSUE_ILLEGAL_EN
  logic       ill;
  logic [7:0] icnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  alu_ctrl_issue dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .instr_valid_i (iv),
    .instr_ready_o (ir),
    .opcode_i      (op),
    .funct_i       (fn),
    .ctrl_valid_o  (cv),
    .ctrl_ready_i  (cr),
    .ctrl_o        (ctrl),
    .imm_sel_o     (imm),
`ifdef ALU_ISSUE_ILLEGAL_EN
    .shamt_sel_o   (sh),
    .illegal_o     (ill),
    .illegal_cnt_o (icnt)
`else
    .shamt_sel_o   (sh)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic [3:0] ctrl;
    logic       imm;
    logic       sh;
    logic       ill;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] o,
                       input logic [5:0] f, input logic r);
    iv = v;
    op = o;
    fn = f;
    cr = r;
  endtask

  task automatic chk_head(input string nm, input logic [3:0] c,
                          input logic i, input logic s);
    chk({nm, ".valid"}, {31'd0, cv}, 32'd1);
    chk({nm, ".ctrl"}, {28'd0, ctrl}, {28'd0, c});
    chk({nm, ".imm"}, {31'd0, imm}, {31'd0, i});
    chk({nm, ".shamt"}, {31'd0, sh}, {31'd0, s});
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, {31'd0, cv}, 32'd0);
    chk({nm, ".ctrl"}, {28'd0, ctrl}, 32'd0);
    chk({nm, ".imm"}, {31'd0, imm}, 32'd0);
    chk({nm, ".shamt"}, {31'd0, sh}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk({nm, ".ill"}, {31'd0, ill}, 32'd0);
`endif
  endtask

  initial begin
    vecs[0]  = '{6'b000000, 6'b100001, 4'b0010, 0, 0, 0};
    vecs[1]  = '{6'b000000, 6'b100011, 4'b0110, 0, 0, 0};
    vecs[2]  = '{6'b000000, 6'b100100, 4'b0000, 0, 0, 0};
    vecs[3]  = '{6'b000000, 6'b100101, 4'b0001, 0, 0, 0};
    vecs[4]  = '{6'b000000, 6'b101010, 4'b1000, 0, 0, 0};
    vecs[5]  = '{6'b000000, 6'b101011, 4'b0111, 0, 0, 0};
    vecs[6]  = '{6'b000000, 6'b000011, 4'b1001, 0, 1, 0};
    vecs[7]  = '{6'b000000, 6'b000111, 4'b1001, 0, 0, 0};
    vecs[8]  = '{6'b000000, 6'b100000, 4'b0010, 0, 0, 1};
    vecs[9]  = '{6'b000100, 6'b100100, 4'b0110, 0, 0, 0};
    vecs[10] = '{6'b000101, 6'b000011, 4'b0110, 0, 0, 0};
    vecs[11] = '{6'b001000, 6'b000000, 4'b0010, 1, 0, 0};
    vecs[12] = '{6'b001011, 6'b000000, 4'b0111, 1, 0, 0};
    vecs[13] = '{6'b001101, 6'b000000, 4'b0001, 1, 0, 0};
    vecs[14] = '{6'b001111, 6'b000000, 4'b1011, 1, 0, 0};
    vecs[15] = '{6'b111111, 6'b100001, 4'b0010, 0, 0, 1};

    rst = 1'b0;
    drive(0, 6'd0, 6'd0, 0);
    #3;
    chk_zero("rst");
    chk("rst.ready", {31'd0, ir}, 32'd0);
`ifdef ALU_ISSUE_ILLEGAL_EN
    chk("rst.cnt", {24'd0, icnt}, 32'd0);
`endif
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rel.ready_pre", {31'd0, ir}, 32'd0);
    tick();
    chk("rel.ready", {31'd0, ir}, 32'd1);

    for (int i = 0; i < 16; i++) begin
      drive(1, vecs[i].op, vecs[i].fn, 1);
      tick();
      chk_head($sformatf("vec%0d", i), vecs[i].ctrl,
               vecs[i].imm, vecs[i].sh);
`ifdef ALU_ISSUE_ILLEGAL_EN
      chk($sformatf("vec%0d.ill", i), {31'd0, ill},
          {31'd0, vecs[i].ill});
`endif
      drive(0, 6'd0, 6'd0, 1);
      tick();
      chk_zero($sformatf("vec%0d.empty", i));
    end

    drive(1, 6'b001101, 6'd0, 0);
    tick();
    chk_head("ori", 4'b0001, 1, 0);
    chk("ori.ready", {31'd0, ir}, 32'd1);
    drive(1, 6'b001111, 6'd0, 0);
    tick();
    chk("full.ready", {31'd0, ir}, 32'd0);
    chk_head("full.hold", 4'b0001, 1, 0);
    drive(0, 6'd0, 6'd0, 0);
    tick();
    chk_head("full.hold2", 4'b0001, 1, 0);

    drive(1, 6'b000000, 6'b101010, 1);
    tick();
    chk_head("lui", 4'b1011, 1, 0);
    chk("lui.ready", {31'd0, ir}, 32'd1);

    drive(1, 6'b000000, 6'b000011, 1);
    tick();
    chk_head("sra", 4'b1001, 0, 1);
    chk("sra.ready", {31'd0, ir}, 32'd1);
    drive(0, 6'd0, 6'd0, 1);
    tick();
    chk_zero("drain");

    drive(1, 6'b000000, 6'b100001, 0);
    tick();
    drive(1, 6'b000000, 6'b100100, 0);
    tick();
    chk("pre_rst.ready", {31'd0, ir}, 32'd0);
    drive(0, 6'd0, 6'd0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("arst");
    chk("arst.ready", {31'd0, ir}, 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("arst_rel.ready", {31'd0, ir}, 32'd1);
    chk_zero("arst_rel");
    drive(0, 6'd0, 6'd0, 1);
    tick();
    chk_zero("arst_stale");

`ifdef ALU_ISSUE_ILLEGAL_EN
    drive(1, 6'b111111, 6'd0, 0);
    tick();
    chk_head("ill", 4'b0010, 0, 0);
    chk("ill.flag", {31'd0, ill}, 32'd1);
    chk("ill.cnt1", {24'd0, icnt}, 32'd1);
    drive(1, 6'b111111, 6'd0, 1);
    for (int k = 0; k < 300; k++) begin
      tick();
    end
    chk("ill.sat", {24'd0, icnt}, 32'hFF);
    drive(0, 6'd0, 6'd0, 1);
    tick();
    chk("ill.sat_hold", {24'd0, icnt}, 32'hFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_fail);
    $finish;
  end

endmodule
